// File: rtl/config_seq_pkg.sv
// Shared constants, header field layout and FSM state type for the configuration sequencer.
package config_seq_pkg;

   localparam logic [7:0] HDR_MAGIC = 8'hFA;

   // Header word field positions
   localparam int unsigned MagicMsb = 31;
   localparam int unsigned MagicLsb = 24;
   localparam int unsigned ColMsb   = 23;
   localparam int unsigned ColLsb   = 12;
   localparam int unsigned FrameMsb = 4;
   localparam int unsigned FrameLsb = 0;

   localparam int unsigned ColW   = ColMsb - ColLsb + 1;
   localparam int unsigned FrameW = FrameMsb - FrameLsb + 1;

   typedef enum logic [1:0] {IDLE, DATA, STROBE, HOLD} state_e;

   typedef struct packed {
      logic [7:0]        magic;
      logic [ColW-1:0]   col;
      logic [FrameW-1:0] frame;
   } hdr_t;

endpackage

// File: rtl/cfg_onehot_dec.sv
// Registered index-to-one-hot decoder; drives the FrameStrobe lines straight from flops.
module cfg_onehot_dec #(
   parameter int unsigned Width = 1200,
   parameter int unsigned IdxW  = $clog2(Width)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [IdxW-1:0]  idx_i,
   output logic [Width-1:0] onehot_o
);

   logic [Width-1:0] onehot_d;
   logic [Width-1:0] onehot_q;

   // Decode the requested line; all zero when not enabled
   always_comb begin
      onehot_d = '0;
      for (int unsigned i = 0; i < Width; i++) begin
         onehot_d[i] = en_i && (idx_i == IdxW'(i));
      end
   end

   // Output flops; asynchronous reset clears every strobe line at once
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         onehot_q <= '0;
      end else begin
         onehot_q <= onehot_d;
      end
   end

   assign onehot_o = onehot_q;

endmodule

// File: rtl/config_frame_sequencer.sv
// Assembles one configuration frame from a word stream, presents it on FrameData and
// fires a single FrameStrobe line for the addressed column/frame.
module config_frame_sequencer
   import config_seq_pkg::*;
#(
   parameter int unsigned NumRows         = 34,
   parameter int unsigned NumCols         = 60,
   parameter int unsigned MaxFramesPerCol = 20,
   parameter int unsigned FrameBitsPerRow = 32,
   parameter int unsigned StrobeCycles    = 2,
   parameter int unsigned HoldCycles      = 1
) (
   input  logic                                 UserCLK,
   input  logic                                 rst,
   input  logic [31:0]                          cfg_data,
   input  logic                                 cfg_valid,
   output logic                                 cfg_ready,
   input  logic                                 cfg_abort,
   output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
   output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
   output logic                                 busy,
   output logic                                 frame_done,
   output logic                                 cfg_err
);

   localparam int unsigned CntW       = $clog2(NumRows);
   localparam int unsigned NumStrobes = NumCols * MaxFramesPerCol;
   localparam int unsigned IdxW       = $clog2(NumStrobes);
   localparam int unsigned StrW       = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
   localparam int unsigned HoldW      = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
   localparam logic [CntW-1:0] LastRow = CntW'(NumRows - 1);

   state_e state_q, state_d;

   logic [CntW-1:0]   cnt_q;
   logic [ColW-1:0]   col_q;
   logic [FrameW-1:0] frame_q;
   logic              drop_q;
   logic              err_q;
   logic [StrW-1:0]   str_cnt_q;
   logic [HoldW-1:0]  hold_cnt_q;
   logic [NumRows-1:0][FrameBitsPerRow-1:0] rows_q;

   hdr_t            hdr;
   logic            take;
   logic            hdr_magic_ok;
   logic            hdr_range_bad;
   logic            last_word;
   logic            str_last;
   logic            hold_last;
   logic            strobe_en;
   logic [IdxW-1:0] strobe_idx;

   assign hdr = '{magic: cfg_data[MagicMsb:MagicLsb],
                  col:   cfg_data[ColMsb:ColLsb],
                  frame: cfg_data[FrameMsb:FrameLsb]};

   // Abort overrides a simultaneous handshake, so the word is never taken
   assign take          = cfg_valid && cfg_ready && !cfg_abort;
   assign hdr_magic_ok  = (hdr.magic == HDR_MAGIC);
   // Widen before comparing so out-of-range high bits can never alias into range
   assign hdr_range_bad = (32'(hdr.col) >= NumCols) || (32'(hdr.frame) >= MaxFramesPerCol);
   assign last_word     = (cnt_q == LastRow);
   assign str_last      = (str_cnt_q == StrW'(StrobeCycles - 1));
   assign hold_last     = (hold_cnt_q == HoldW'(HoldCycles - 1));
   assign strobe_idx    = IdxW'(32'(col_q) * MaxFramesPerCol + 32'(frame_q));

   // State register
   always_ff @(posedge UserCLK or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (take && hdr_magic_ok) state_d = DATA;
         end
         DATA: begin
            if (cfg_abort) begin
               state_d = IDLE;
            end else if (take && last_word) begin
               state_d = drop_q ? IDLE : STROBE;
            end
         end
         STROBE: begin
            if (cfg_abort || str_last) state_d = HOLD;
         end
         HOLD: begin
            if (hold_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and strobe-request decode
   always_comb begin
      cfg_ready  = (state_q == IDLE) || (state_q == DATA);
      busy       = (state_q != IDLE);
      frame_done = (state_q == HOLD) && hold_last;
      // Strobe flop is loaded on the last-word edge, then kept for the remaining cycles
      strobe_en  = ((state_q == DATA) && take && last_word && !drop_q) ||
                   ((state_q == STROBE) && !cfg_abort && !str_last);
   end

   // Word counter and latched header fields
   always_ff @(posedge UserCLK or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         col_q   <= '0;
         frame_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && take && hdr_magic_ok) begin
            col_q   <= hdr.col;
            frame_q <= hdr.frame;
            drop_q  <= hdr_range_bad;
         end
         if (state_q == DATA) begin
            if (cfg_abort) begin
               cnt_q <= '0;
            end else if (take) begin
               cnt_q <= last_word ? '0 : cnt_q + CntW'(1);
            end
         end
      end
   end

   // Row register file; only written while collecting data words
   always_ff @(posedge UserCLK or negedge rst) begin
      if (!rst) begin
         rows_q <= '0;
      end else if (state_q == DATA && take) begin
         rows_q[cnt_q] <= cfg_data[FrameBitsPerRow-1:0];
      end
   end

   // Strobe and hold duration counters
   always_ff @(posedge UserCLK or negedge rst) begin
      if (!rst) begin
         str_cnt_q  <= '0;
         hold_cnt_q <= '0;
      end else begin
         str_cnt_q  <= (state_q == STROBE) ? str_cnt_q + StrW'(1) : '0;
         hold_cnt_q <= (state_q == HOLD) ? hold_cnt_q + HoldW'(1) : '0;
      end
   end

   // Sticky error: bad magic or out-of-range header
   always_ff @(posedge UserCLK or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && take && (!hdr_magic_ok || hdr_range_bad)) begin
         err_q <= 1'b1;
      end
   end

   cfg_onehot_dec #(
      .Width (NumStrobes),
      .IdxW  (IdxW)
   ) u_strobe_dec (
      .clk_i    (UserCLK),
      .rst_ni   (rst),
      .en_i     (strobe_en),
      .idx_i    (strobe_idx),
      .onehot_o (FrameStrobe)
   );

   assign FrameData = rows_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Randomised scoreboard bench for config_frame_sequencer.
module tb_config_frame_sequencer;

   localparam int NR = 34;
   localparam int NC = 60;
   localparam int MF = 20;
   localparam int FB = 32;
   localparam int SC = 2;
   localparam int DW = NR * FB;
   localparam int SW = NC * MF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   cfg_data = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic          cfg_abort = 1'b0;
   logic [DW-1:0] FrameData;
   logic [SW-1:0] FrameStrobe;
   logic          busy;
   logic          frame_done;
   logic          cfg_err;

   always #5 clk = ~clk;

   config_frame_sequencer #(
      .NumRows         (NR),
      .NumCols         (NC),
      .MaxFramesPerCol (MF),
      .FrameBitsPerRow (FB),
      .StrobeCycles    (SC),
      .HoldCycles      (1)
   ) dut (
      .UserCLK     (clk),
      .rst         (rst_n),
      .cfg_data    (cfg_data),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_abort   (cfg_abort),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .frame_done  (frame_done),
      .cfg_err     (cfg_err)
   );

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl_rows[NR];
   bit          mdl_err = 1'b0;
   bit          mon_en = 1'b1;
   bit          rnd_gaps = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_data(input string nm, input logic [DW-1:0] exp);
      n_cmp++;
      if (FrameData !== exp) begin
         n_bad++;
         for (int r = 0; r < NR; r++) begin
            if (FrameData[r*FB +: FB] !== exp[r*FB +: FB]) begin
               $display("FAIL %s: row %0d got %h expected %h at %0t", nm, r,
                        FrameData[r*FB +: FB], exp[r*FB +: FB], $time);
               break;
            end
         end
      end
   endtask

   function automatic logic [DW-1:0] mdl_frame();
      logic [DW-1:0] v;
      for (int r = 0; r < NR; r++) v[r*FB +: FB] = mdl_rows[r];
      return v;
   endfunction

   function automatic int first_set(input logic [SW-1:0] v);
      for (int i = 0; i < SW; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] hdr_word(input int col, input int fr);
      logic [31:0] h;
      logic [11:0] c;
      logic [4:0]  f;
      c = 12'(col);
      f = 5'(fr);
      h = $urandom;            // bits outside the fields are don't-care
      h[31:24] = 8'hFA;
      h[23:12] = c;
      h[4:0]   = f;
      return h;
   endfunction

   // Present one word and hold it until the handshake completes
   task automatic send(input logic [31:0] w, input bit ab);
      int n;
      n = 0;
      if (rnd_gaps) begin
         int g;
         g = $urandom_range(0, 3);
         repeat (g) begin
            @(negedge clk);
            cfg_valid = 1'b0;
         end
      end
      @(negedge clk);
      cfg_data  = w;
      cfg_valid = 1'b1;
      cfg_abort = ab;
      while (!cfg_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
   endtask

   task automatic pulse_abort();
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_abort = 1'b1;
      @(posedge clk);
      #1;
      cfg_abort = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("idle_timeout", 0, 1);
   endtask

   // Header plus NR words; abort_at >= 0 aborts instead of sending that word
   task automatic do_frame(input int col, input int fr, input int abort_at, input bit abort_valid,
                           input bit expect_strobe, input bit seq);
      logic [31:0] words[NR];
      bit          oor;
      exp_t        x;
      oor = (col >= NC) || (fr >= MF);
      for (int k = 0; k < NR; k++) words[k] = seq ? 32'(k) : $urandom;
      send(hdr_word(col, fr), 1'b0);
      if (oor) mdl_err = 1'b1;
      for (int k = 0; k < NR; k++) begin
         if (k == abort_at) begin
            if (abort_valid) send(words[k], 1'b1);
            else pulse_abort();
            return;
         end
         mdl_rows[k] = words[k];
         if (k == NR - 1 && !oor && expect_strobe) begin
            x.idx  = col * MF + fr;
            x.data = mdl_frame();
            exp_q.push_back(x);
         end
         send(words[k], 1'b0);
      end
   endtask

   // Monitor: pops the scoreboard whenever a strobe appears and checks its whole lifetime
   initial begin
      int            len;
      int            idx;
      logic [DW-1:0] snap;
      exp_t          x;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) continue;
         if (FrameStrobe == '0) begin
            chk("frame_done_outside_hold", frame_done, 0);
         end else begin
            chk("strobe_onehot", $countones(FrameStrobe), 1);
            chk("ready_in_strobe", cfg_ready, 0);
            chk("busy_in_strobe", busy, 1);
            idx = first_set(FrameStrobe);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_strobe: got bit %0d expected none at %0t", idx, $time);
            end else begin
               x = exp_q.pop_front();
               chk("strobe_idx", idx, x.idx);
               chk_data("framedata_at_strobe", x.data);
            end
            snap = FrameData;
            len  = 1;
            while (len < 20) begin
               @(negedge clk);
               if (!rst_n || FrameStrobe == '0) break;
               chk("strobe_onehot", $countones(FrameStrobe), 1);
               chk("strobe_same_bit", first_set(FrameStrobe), idx);
               chk_data("framedata_stable_strobe", snap);
               chk("ready_in_strobe", cfg_ready, 0);
               len++;
            end
            if (!rst_n || !mon_en) continue;
            chk("strobe_len", len, SC);
            chk("frame_done_hold", frame_done, 1);
            chk("ready_in_hold", cfg_ready, 0);
            chk_data("framedata_stable_hold", snap);
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int kind;
      int col;
      int fr;
      for (int r = 0; r < NR; r++) mdl_rows[r] = '0;
      repeat (2) @(negedge clk);
      chk("rst_strobe", FrameStrobe, 0);
      chk("rst_ready", cfg_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_ready", cfg_ready, 1);
      chk("reset_err", cfg_err, 0);
      chk("reset_done", frame_done, 0);
      chk_data("reset_framedata", '0);

      // Basic frame, col 3 frame 7 -> bit 67, rows 0..33
      do_frame(3, 7, -1, 1'b0, 1'b1, 1'b1);
      wait_idle();
      chk("t1_err", cfg_err, 0);

      // Bad magic in IDLE, then a good frame
      send(32'h1234_0000, 1'b0);
      mdl_err = 1'b1;
      @(negedge clk);
      chk("t2_busy_after_bad", busy, 0);
      chk("t2_err", cfg_err, 1);
      do_frame(10, 19, -1, 1'b0, 1'b1, 1'b0);
      wait_idle();

      // Out-of-range headers consume their words without strobing
      do_frame(60, 0, -1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t3_ready", cfg_ready, 1);
      chk("t3_busy", busy, 0);
      chk("t3_err", cfg_err, 1);
      do_frame(69, 2, -1, 1'b0, 1'b1, 1'b0);
      do_frame(0, 20, -1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t3_busy2", busy, 0);

      // Abort after 10 data words, then a complete frame restarts at row 0
      do_frame(12, 4, 10, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4_busy_after_abort", busy, 0);
      do_frame(12, 4, -1, 1'b0, 1'b1, 1'b0);
      do_frame(40, 0, 0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4_busy_after_abort2", busy, 0);
      do_frame(59, 19, -1, 1'b0, 1'b1, 1'b0);
      wait_idle();

      // Asynchronous reset while strobing
      mon_en = 1'b0;
      do_frame(25, 5, -1, 1'b0, 1'b0, 1'b0);
      begin
         int n;
         n = 0;
         while (FrameStrobe == '0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("t5_strobe_seen", FrameStrobe != '0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_strobe_async", FrameStrobe, 0);
      chk("t5_ready", cfg_ready, 1);
      chk("t5_busy", busy, 0);
      chk("t5_err", cfg_err, 0);
      mdl_err = 1'b0;
      for (int r = 0; r < NR; r++) mdl_rows[r] = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_data("t5_framedata_cleared", '0);
      mon_en = 1'b1;

      // Randomised traffic with valid gaps
      rnd_gaps = 1'b1;
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            col = $urandom_range(0, 254);
            if (col >= 8'hFA) col++;
            send({8'(col), 24'($urandom)}, 1'b0);
            mdl_err = 1'b1;
         end else if (kind == 1) begin
            if ($urandom_range(0, 1) == 0) begin
               col = $urandom_range(NC, 4095);
               fr  = $urandom_range(0, 31);
            end else begin
               col = $urandom_range(0, NC - 1);
               fr  = $urandom_range(MF, 31);
            end
            do_frame(col, fr, -1, 1'b0, 1'b1, 1'b0);
         end else if (kind == 2) begin
            do_frame($urandom_range(0, NC - 1), $urandom_range(0, MF - 1),
                     $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         end else begin
            do_frame($urandom_range(0, NC - 1), $urandom_range(0, MF - 1), -1, 1'b0, 1'b1, 1'b0);
         end
         @(negedge clk);
         chk("rnd_err", cfg_err, mdl_err);
      end

      rnd_gaps = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
